// File: rtl/counter_step_ctrl_pkg.sv
// Shared types and constants for the counter_step_ctrl button-to-counter block.
//   state_e   : FSM states of the single-owner press/release arbiter
//   btn_idx_e : button index / owner encoding (BTN_NONE when no button owns the FSM)
//   NUM_BTN   : number of physical push-buttons (clear, up, down)
package counter_step_ctrl_pkg;

    localparam int unsigned NUM_BTN = 3;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        COMMIT
    } state_e;

    typedef enum logic [1:0] {
        BTN_CLR  = 2'd0,
        BTN_UP   = 2'd1,
        BTN_DN   = 2'd2,
        BTN_NONE = 2'd3
    } btn_idx_e;

endpackage

// File: rtl/button_debounce.sv
// Synchronises and debounces one raw push-button.
//   clk    : system clock
//   reset  : asynchronous active-low reset
//   raw    : asynchronous raw button level
//   rise   : 1-cycle pulse, coincident with the debounced level going high
//   fall   : 1-cycle pulse, coincident with the debounced level going low
// The debounced level flips only after DEBOUNCE_CYCLES consecutive synchronised samples
// that differ from it; any sample agreeing with the current level restarts the count.
module button_debounce
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic rise,
    output logic fall
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_q;
    logic            level_q, level_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            rise_q, fall_q;
    logic            synced;

    assign synced = sync_q[1];

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (synced != level_q) begin
            if (cnt_q == CntLast) begin
                level_d = synced;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw};
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= ~level_q & level_d;
            fall_q  <= level_q & ~level_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/counter_step_ctrl.sv
// Arbitrates three debounced push-buttons (clear/up/down) onto one wrapping counter.
//   clk     : system clock
//   reset   : asynchronous active-low reset
//   btn_raw : raw buttons, [0]=clear [1]=up [2]=down
//   enable  : gates new presses only; an armed press still commits
//   count   : current counter value
//   step    : 1-cycle pulse when count is updated
//   wrap    : 1-cycle pulse with step when up/down wrapped
//   busy    : FSM not IDLE
//   owner   : index of the button owning the FSM, 3 when IDLE
// Optional macro AUTOREPEAT_EN: holding up/down repeats the step after REPEAT_DELAY cycles
// and every REPEAT_PERIOD cycles after; a release following a repeat does not commit again.
module counter_step_ctrl
    import counter_step_ctrl_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH     = 3,
    parameter int unsigned COUNT_MAX       = 7,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY    = 500,
    parameter int unsigned REPEAT_PERIOD   = 100
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BTN-1:0]     btn_raw,
    input  logic                   enable,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   step,
    output logic                   wrap,
    output logic                   busy,
    output logic [1:0]             owner
);

    localparam logic [COUNT_WIDTH-1:0] CountMax = COUNT_WIDTH'(COUNT_MAX);

    if (COUNT_MAX >= (1 << COUNT_WIDTH) || DEBOUNCE_CYCLES == 0 ||
        REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_bad_cfg
        $error("counter_step_ctrl: illegal parameter combination");
    end

    logic [NUM_BTN-1:0] rise, fall;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (clk),
            .reset(reset),
            .raw  (btn_raw[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

    state_e                 state_q, state_d;
    btn_idx_e               owner_q, owner_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   step_q, step_d;
    logic                   wrap_q, wrap_d;
    logic                   owner_fall;
    logic                   do_op;

    logic                   up_wrap, dn_wrap;
    logic [COUNT_WIDTH-1:0] up_val, dn_val;

    assign up_wrap = (count_q == CountMax);
    assign up_val  = up_wrap ? '0 : count_q + 1'b1;
    assign dn_wrap = (count_q == '0);
    assign dn_val  = dn_wrap ? CountMax : count_q - 1'b1;

`ifdef AUTOREPEAT_EN
    localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                     : REPEAT_PERIOD;
    localparam int unsigned RptW   = $clog2(RptMax + 1);

    // Counts down to the next repeat; reloaded on arm and after every repeat.
    logic [RptW-1:0] rpt_q, rpt_d;
    logic            repeated_q, repeated_d;
`endif

    always_comb begin
        unique case (owner_q)
            BTN_CLR: owner_fall = fall[0];
            BTN_UP:  owner_fall = fall[1];
            BTN_DN:  owner_fall = fall[2];
            default: owner_fall = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        count_d = count_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        do_op   = 1'b0;
`ifdef AUTOREPEAT_EN
        rpt_d      = rpt_q;
        repeated_d = repeated_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (enable && (|rise)) begin
                    state_d = ARMED;
                    if (rise[0])      owner_d = BTN_CLR;
                    else if (rise[1]) owner_d = BTN_UP;
                    else              owner_d = BTN_DN;
`ifdef AUTOREPEAT_EN
                    rpt_d      = RptW'(REPEAT_DELAY - 1);
                    repeated_d = 1'b0;
`endif
                end
            end
            ARMED: begin
                if (owner_fall) begin
`ifdef AUTOREPEAT_EN
                    if (repeated_q) begin
                        state_d = IDLE;
                        owner_d = BTN_NONE;
                    end else begin
                        state_d = COMMIT;
                    end
`else
                    state_d = COMMIT;
`endif
                end
`ifdef AUTOREPEAT_EN
                else if (owner_q != BTN_CLR) begin
                    if (rpt_q == '0) begin
                        do_op      = 1'b1;
                        repeated_d = 1'b1;
                        rpt_d      = RptW'(REPEAT_PERIOD - 1);
                    end else begin
                        rpt_d = rpt_q - 1'b1;
                    end
                end
`endif
            end
            COMMIT: begin
                do_op   = 1'b1;
                state_d = IDLE;
                owner_d = BTN_NONE;
            end
            default: begin
                state_d = IDLE;
                owner_d = BTN_NONE;
            end
        endcase

        if (do_op) begin
            step_d = 1'b1;
            unique case (owner_q)
                BTN_CLR: count_d = '0;
                BTN_UP: begin
                    count_d = up_val;
                    wrap_d  = up_wrap;
                end
                BTN_DN: begin
                    count_d = dn_val;
                    wrap_d  = dn_wrap;
                end
                default: step_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= BTN_NONE;
            count_q <= '0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            count_q <= count_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
        end
    end

`ifdef AUTOREPEAT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rpt_q      <= '0;
            repeated_q <= 1'b0;
        end else begin
            rpt_q      <= rpt_d;
            repeated_q <= repeated_d;
        end
    end
`endif

    assign count = count_q;
    assign step  = step_q;
    assign wrap  = wrap_q;
    assign busy  = (state_q != IDLE);
    assign owner = owner_q;

endmodule

// File: tb/tb_counter_step_ctrl.sv
// Directed bench for counter_step_ctrl with a step scoreboard.
module tb_counter_step_ctrl;

    localparam int unsigned CW   = 3;
    localparam int unsigned CMAX = 5;

    logic          clk;
    logic          reset;
    logic [2:0]    btn_raw;
    logic          enable;
    logic [CW-1:0] count;
    logic          step;
    logic          wrap;
    logic          busy;
    logic [1:0]    owner;

    counter_step_ctrl #(
        .COUNT_WIDTH    (CW),
        .COUNT_MAX      (CMAX),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(btn_raw),
        .enable (enable),
        .count  (count),
        .step   (step),
        .wrap   (wrap),
        .busy   (busy),
        .owner  (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] cnt;
        logic          wrap;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_count = 0;
    logic saw_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference arithmetic; pushes the step the DUT should eventually produce.
    task automatic push_op(input int idx);
        logic w;
        w = 1'b0;
        case (idx)
            0: m_count = 0;
            1: begin
                w = (m_count == CMAX);
                m_count = w ? 0 : m_count + 1;
            end
            default: begin
                w = (m_count == 0);
                m_count = w ? CMAX : m_count - 1;
            end
        endcase
        exp_q.push_back('{cnt: CW'(m_count), wrap: w});
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic watch(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (busy) saw_busy = 1'b1;
        end
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        while (busy !== 1'b1 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic press(input int idx, input int hold);
        push_op(idx);
        btn_raw[idx] = 1'b1;
        cycles(hold);
        btn_raw[idx] = 1'b0;
        cycles(12);
    endtask

    // Scoreboard: every step pulse must match the oldest expected operation.
    always @(negedge clk) begin
        checks++;
        assert (!(wrap && !step))
        else begin
            errors++;
            $error("FAIL wrap_without_step observed wrap=1 step=0 expected wrap=0");
        end
        if (step === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0)
            else begin
                errors++;
                $error("FAIL unexpected_step observed count=%0d expected no step", count);
            end
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                assert (count === e.cnt && wrap === e.wrap)
                else begin
                    errors++;
                    $error("FAIL step_result observed count=%0d wrap=%0b expected count=%0d wrap=%0b",
                           count, wrap, e.cnt, e.wrap);
                end
            end
        end
    end

    initial begin
        int n;
        reset   = 1'b0;
        btn_raw = 3'b000;
        enable  = 1'b1;
        cycles(3);
        chk("reset_count", 32'(count), 0);
        chk("reset_step", 32'(step), 0);
        chk("reset_wrap", 32'(wrap), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_owner", 32'(owner), 3);
        reset = 1'b1;
        cycles(3);

        // 1: clean up press; debounced rise at +6, FSM arms one edge later.
        push_op(1);
        btn_raw[1] = 1'b1;
        wait_busy(n);
        chk("t1_arm_latency", n, 7);
        chk("t1_owner", 32'(owner), 1);
        cycles(3);
        btn_raw[1] = 1'b0;
        watch(0);
        cycles(12);
        chk("t1_count", 32'(count), 1);
        chk("t1_idle_owner", 32'(owner), 3);
        chk("t1_idle_busy", 32'(busy), 0);

        // 2: bouncing up press must not arm until stable.
        saw_busy = 1'b0;
        for (int r = 0; r < 3; r++) begin
            btn_raw[1] = 1'b1;
            watch(3);
            btn_raw[1] = 1'b0;
            watch(1);
        end
        chk("t2_no_arm_bounce", 32'(saw_busy), 0);
        push_op(1);
        btn_raw[1] = 1'b1;
        wait_busy(n);
        chk("t2_arm_latency", n, 7);
        cycles(3);
        btn_raw[1] = 1'b0;
        cycles(12);
        chk("t2_count", 32'(count), 2);

        // 3: wrap up at max, wrap down at zero.
        press(1, 10);
        press(1, 10);
        press(1, 10);
        chk("t3_at_max", 32'(count), 5);
        press(1, 10);
        chk("t3_up_wrap", 32'(count), 0);
        press(2, 10);
        chk("t3_dn_wrap", 32'(count), 5);

        // 4: same-cycle clear+up at count 3; clear wins, up release ignored.
        press(2, 10);
        press(2, 10);
        chk("t4_start", 32'(count), 3);
        push_op(0);
        btn_raw = 3'b011;
        wait_busy(n);
        chk("t4_owner", 32'(owner), 0);
        btn_raw[1] = 1'b0;
        cycles(12);
        chk("t4_still_busy", 32'(busy), 1);
        chk("t4_count_hold", 32'(count), 3);
        btn_raw[0] = 1'b0;
        cycles(12);
        chk("t4_count", 32'(count), 0);

        // 5: reset while armed drops the press; held button re-arms after release.
        press(1, 10);
        btn_raw[1] = 1'b1;
        wait_busy(n);
        chk("t5_armed", 32'(busy), 1);
        cycles(2);
        reset = 1'b0;
        m_count = 0;
        #1;
        chk("t5_reset_count", 32'(count), 0);
        chk("t5_reset_busy", 32'(busy), 0);
        chk("t5_reset_owner", 32'(owner), 3);
        @(posedge clk);
        #1;
        reset = 1'b1;
        wait_busy(n);
        chk("t5_rearm_latency", n, 7);
        cycles(5);
        chk("t5_no_step_held", 32'(count), 0);
        push_op(1);
        btn_raw[1] = 1'b0;
        cycles(12);
        chk("t5_count", 32'(count), 1);

        // 6: long up hold from zero (auto-repeat only with the macro).
        press(0, 10);
`ifdef AUTOREPEAT_EN
        push_op(1);
        push_op(1);
        push_op(1);
`else
        push_op(1);
`endif
        btn_raw[1] = 1'b1;
        cycles(40);
        btn_raw[1] = 1'b0;
        cycles(12);
`ifdef AUTOREPEAT_EN
        chk("t6_count", 32'(count), 3);
`else
        chk("t6_count", 32'(count), 1);
`endif

        // 7: enable low ignores a press; dropping enable while armed still commits.
        enable = 1'b0;
        saw_busy = 1'b0;
        btn_raw[2] = 1'b1;
        watch(10);
        btn_raw[2] = 1'b0;
        watch(12);
        chk("t7_disabled_no_arm", 32'(saw_busy), 0);
        chk("t7_disabled_count", 32'(count), m_count);
        enable = 1'b1;
        push_op(2);
        btn_raw[2] = 1'b1;
        wait_busy(n);
        chk("t7_owner", 32'(owner), 2);
        enable = 1'b0;
        cycles(3);
        btn_raw[2] = 1'b0;
        cycles(12);
        chk("t7_count", 32'(count), m_count);
        enable = 1'b1;

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
